// File: rtl/fpu_add_operand_queue.sv
// Operand-pair FIFO feeding the FP adder: valid/ready in, hold-gated issue out.
// Define FPU_QUEUE_FTZ_EN to flush denormal operands to signed zero on enqueue.
module fpu_add_operand_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_vld,
  output logic              s_rdy,
  input  logic [31:0]       s_a,
  input  logic [31:0]       s_b,
  input  logic              hold,
  input  logic              flush,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic              add_vld,
  output logic [ADDR_W:0]   level,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  issued_cnt
);
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, STALL = 2'b10} state_t;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_t          st;
  logic [63:0]     mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, level_nxt;
  logic            empty, push, pop;
  logic [63:0]     head;

  function automatic logic [31:0] ftz(input logic [31:0] x);
`ifdef FPU_QUEUE_FTZ_EN
    if (x[30:23] == 8'd0 && x[22:0] != 23'd0) return {x[31], 31'd0};
    else                                       return x;
`else
    return x;
`endif
  endfunction

  assign s_rdy = (level != FULL_LVL);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = s_vld && s_rdy && !flush;
  assign pop   = !empty && !hold && !flush;
  assign head  = mem[rd_ptr[ADDR_W-1:0]];
  assign state = st;

  always_comb begin
    level_nxt = level;
    if (flush) level_nxt = '0;
    else       level_nxt = level + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= {ftz(s_a), ftz(s_b)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_vld    <= 1'b0;
      issued_cnt <= '0;
      st         <= IDLE;
    end else begin
      level   <= level_nxt;
      add_vld <= pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (pop) begin
        add_a      <= head[63:32];
        add_b      <= head[31:0];
        issued_cnt <= issued_cnt + 1'b1;
      end
      // State tracks what the queue will hold after this edge and whether it is blocked.
      if (flush || level_nxt == '0) st <= IDLE;
      else if (hold)                st <= STALL;
      else                          st <= ISSUE;
    end
  end
endmodule
